// File: rtl/nf_i_mem_resp.sv
// Instruction-memory responder: accepts a fetch address, waits WAIT_ST cycles,
// issues one synchronous memory read and returns the word with its PC and a
// one-cycle valid strobe. A branch flush kills the in-flight fetch.
module nf_i_mem_resp #(
    parameter int          WAIT_ST = 0,
    parameter int          ADDR_W  = 10,
    parameter logic [31:0] NOP     = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [31:0]       addr_i,
    input  logic              req_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic [31:0]       instr_o,
    output logic [31:0]       pc_o,
    output logic              instr_vld_o,
    output logic              misalign_o,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_READ = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic        kill;
    logic [31:0] addr_q;

    logic        aligned_req;
    logic        drop;

    assign aligned_req = req_i && (addr_i[1:0] == 2'b00);
    // A flush seen while the response is being captured kills it as well.
    assign drop        = kill | flush_i;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a flush during the wait phase abandons the fetch before any read.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (aligned_req) begin
                    state_next = (WAIT_ST > 0) ? ST_WAIT : ST_READ;
                end
            end
            ST_WAIT: begin
                if (flush_i) begin
                    state_next = ST_IDLE;
                end else if (cnt == 4'd1) begin
                    state_next = ST_READ;
                end
            end
            ST_READ: state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Transaction bookkeeping: latched address, wait counter and kill flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q <= '0;
            cnt    <= '0;
            kill   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (aligned_req) begin
                        addr_q <= addr_i;
                        cnt    <= 4'(WAIT_ST);
                        kill   <= 1'b0;
                    end
                end
                ST_WAIT: cnt <= cnt - 4'd1;
                ST_READ: begin
                    // The read still completes; only its result is discarded.
                    if (flush_i) begin
                        kill <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Response registers: strobes default low, instr/pc hold between strobes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            instr_o     <= NOP;
            pc_o        <= '0;
            instr_vld_o <= 1'b0;
            misalign_o  <= 1'b0;
        end else begin
            instr_vld_o <= 1'b0;
            misalign_o  <= 1'b0;
            if (state == ST_IDLE && req_i && addr_i[1:0] != 2'b00) begin
                misalign_o <= 1'b1;
                instr_o    <= NOP;
                pc_o       <= addr_i;
            end else if (state == ST_RESP) begin
                instr_vld_o <= ~drop;
                instr_o     <= drop ? NOP : mem_rdata;
                pc_o        <= addr_q;
            end
        end
    end

    assign stall_o  = (state != ST_IDLE);
    assign mem_rd   = (state == ST_READ);
    // Upper address bits are dropped, so fetches wrap modulo the memory size.
    assign mem_addr = (state == ST_READ) ? addr_q[ADDR_W+1:2] : '0;

endmodule

// File: tb/tb_nf_i_mem_resp.sv
// Randomized bench for nf_i_mem_resp: two instances (WAIT_ST 0 and 3) run
// against a timeline model of each fetch (accept edge, read cycle, strobe cycle).
module tb_nf_i_mem_resp;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          WS [2] = '{0, 3};

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req   [2];
    logic        flush [2];
    logic [31:0] addr  [2];
    logic        stall [2];
    logic        vld   [2];
    logic        mis   [2];
    logic        mrd   [2];
    logic [31:0] instr [2];
    logic [31:0] pc    [2];
    logic [31:0] rdata [2];
    logic [9:0]  maddr [2];
    logic [31:0] mem   [1024];

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: one outstanding fetch described by its accept edge.
    bit          busy    [2];
    int          e       [2];
    logic [31:0] ta      [2];
    bit          killed  [2];
    logic [31:0] last_i  [2];
    logic [31:0] last_pc [2];
    int          mis_p   [2];
    logic [31:0] mis_a   [2];
    int          p;
    bit          did_rst;

    always #5 clk = ~clk;

    nf_i_mem_resp #(.WAIT_ST(0), .ADDR_W(10), .NOP(NOP)) u_dut0 (
        .clk(clk), .resetn(resetn), .addr_i(addr[0]), .req_i(req[0]),
        .flush_i(flush[0]), .stall_o(stall[0]), .instr_o(instr[0]), .pc_o(pc[0]),
        .instr_vld_o(vld[0]), .misalign_o(mis[0]), .mem_addr(maddr[0]),
        .mem_rd(mrd[0]), .mem_rdata(rdata[0])
    );

    nf_i_mem_resp #(.WAIT_ST(3), .ADDR_W(10), .NOP(NOP)) u_dut3 (
        .clk(clk), .resetn(resetn), .addr_i(addr[1]), .req_i(req[1]),
        .flush_i(flush[1]), .stall_o(stall[1]), .instr_o(instr[1]), .pc_o(pc[1]),
        .instr_vld_o(vld[1]), .misalign_o(mis[1]), .mem_addr(maddr[1]),
        .mem_rd(mrd[1]), .mem_rdata(rdata[1])
    );

    // Synchronous instruction memories, data valid the cycle after mem_rd.
    always @(posedge clk) if (mrd[0]) rdata[0] <= mem[maddr[0]];
    always @(posedge clk) if (mrd[1]) rdata[1] <= mem[maddr[1]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h (period %0d)", tag, got, exp, p);
    endtask

    task automatic reset_model();
        for (int i = 0; i < 2; i++) begin
            busy[i]    = 1'b0;
            killed[i]  = 1'b0;
            last_i[i]  = NOP;
            last_pc[i] = '0;
            mis_p[i]   = -10;
        end
    endtask

    task automatic check_reset_vals(input int i);
        chk($sformatf("rst_stall%0d", i), {31'd0, stall[i]}, 32'd0);
        chk($sformatf("rst_mem_rd%0d", i), {31'd0, mrd[i]}, 32'd0);
        chk($sformatf("rst_mem_addr%0d", i), {22'd0, maddr[i]}, 32'd0);
        chk($sformatf("rst_vld%0d", i), {31'd0, vld[i]}, 32'd0);
        chk($sformatf("rst_mis%0d", i), {31'd0, mis[i]}, 32'd0);
        chk($sformatf("rst_instr%0d", i), instr[i], NOP);
        chk($sformatf("rst_pc%0d", i), pc[i], 32'd0);
    endtask

    // Compare every output of instance i against the model for period p.
    task automatic check_period(input int i);
        bit         s_stall, s_rd, s_strobe, s_mis;
        logic [9:0] xa;
        s_stall  = busy[i] && (p >= e[i]) && (p <= e[i] + WS[i] + 1);
        s_rd     = busy[i] && (p == e[i] + WS[i]);
        s_strobe = busy[i] && (p == e[i] + WS[i] + 2);
        s_mis    = (p == mis_p[i]);
        xa       = s_rd ? ta[i][11:2] : 10'd0;
        if (s_strobe) begin
            last_i[i]  = killed[i] ? NOP : mem[ta[i][11:2]];
            last_pc[i] = ta[i];
        end
        if (s_mis) begin
            last_i[i]  = NOP;
            last_pc[i] = mis_a[i];
        end
        chk($sformatf("stall%0d", i), {31'd0, stall[i]}, {31'd0, s_stall});
        chk($sformatf("mem_rd%0d", i), {31'd0, mrd[i]}, {31'd0, s_rd});
        chk($sformatf("mem_addr%0d", i), {22'd0, maddr[i]}, {22'd0, xa});
        chk($sformatf("vld%0d", i), {31'd0, vld[i]}, {31'd0, s_strobe && !killed[i]});
        chk($sformatf("misalign%0d", i), {31'd0, mis[i]}, {31'd0, s_mis});
        chk($sformatf("instr%0d", i), instr[i], last_i[i]);
        chk($sformatf("pc%0d", i), pc[i], last_pc[i]);
        if (s_strobe) busy[i] = 1'b0;
    endtask

    // Pick inputs for the next edge and record their effect in the model.
    task automatic drive(input int i, input int iter);
        bit          idle;
        logic [31:0] a;
        idle = !busy[i];
        a = $urandom();
        if ($urandom_range(3) != 0) a[1:0] = 2'b00;
        flush[i] = ($urandom_range(7) == 0);
        req[i]   = ($urandom_range(1) == 1);
        if (iter == 0) begin
            a = 32'h0000_1004;   // wraps to word 1 of a 1K-word memory
            flush[i] = 1'b0;
            req[i]   = 1'b1;
        end
        addr[i] = a;
        if (flush[i] && busy[i]) begin
            if (p < e[i] + WS[i]) busy[i] = 1'b0;
            else killed[i] = 1'b1;
        end
        if (idle && req[i]) begin
            if (a[1:0] != 2'b00) begin
                mis_p[i] = p + 1;
                mis_a[i] = a;
            end else begin
                busy[i]   = 1'b1;
                e[i]      = p + 1;
                ta[i]     = a;
                killed[i] = 1'b0;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) mem[k] = $urandom();
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; flush[i] = 1'b0; addr[i] = '0;
        end
        reset_model();
        did_rst = 1'b0;
        p = 0;
        repeat (2) @(negedge clk);
        check_reset_vals(0);
        check_reset_vals(1);
        resetn = 1'b1;

        for (int iter = 0; iter < 2000; iter++) begin
            // Asynchronous reset while the WAIT_ST=3 instance is waiting.
            if (!did_rst && iter >= 1000 &&
                ((busy[1] && p < e[1] + WS[1]) || iter == 1300)) begin
                did_rst = 1'b1;
                resetn = 1'b0;
                #1;
                check_reset_vals(0);
                check_reset_vals(1);
                for (int i = 0; i < 2; i++) begin
                    req[i] = 1'b0; flush[i] = 1'b0;
                end
                @(negedge clk);
                @(negedge clk);
                p = p + 2;
                check_reset_vals(0);
                check_reset_vals(1);
                resetn = 1'b1;
                reset_model();
            end
            drive(0, iter);
            drive(1, iter);
            @(negedge clk);
            p++;
            check_period(0);
            check_period(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/nf_i_mem_resp.md
# nf_i_mem_resp

Instruction-memory responder for the fetch path: the memory-side end of the program-counter/instruction interface driven by the instruction fetch unit. It accepts a fetch address, inserts a configurable number of wait states, issues a single synchronous read to the instruction memory, and returns the instruction word together with its address and a one-cycle valid strobe. While a fetch is in flight it stalls the fetch unit. A branch flush kills the in-flight fetch so that wrong-path instructions never reach decode.

## Interface
- `WAIT_ST`, 0 — extra wait cycles before the memory read; legal range 0..15.
- `ADDR_W`, 10 — word-address width of the instruction memory.
- `NOP`, 32'h0000_0013 — value driven on `instr_o` when no valid instruction is present.

Ports:
- `clk` in 1 — clock; all state updates on the rising edge.
- `resetn` in 1 — asynchronous, active-low reset.
- `addr_i` in 32 — fetch byte address (PC from fetch 1 stage).
- `req_i` in 1 — fetch request, level.
- `flush_i` in 1 — branch taken; kill the in-flight fetch.
- `stall_o` out 1 — fetch unit must hold its PC.
- `instr_o` out 32 — returned instruction.
- `pc_o` out 32 — byte address of `instr_o`.
- `instr_vld_o` out 1 — one-cycle strobe; `instr_o` and `pc_o` are valid.
- `misalign_o` out 1 — one-cycle strobe; the request had `addr_i[1:0] != 0`.
- `mem_addr` out ADDR_W — word address to instruction memory.
- `mem_rd` out 1 — memory read enable.
- `mem_rdata` in 32 — memory data, valid the cycle after `mem_rd`.

## Operation
- FSM states: IDLE, WAIT, READ, RESP. The reset state is IDLE.
- **IDLE:**
  - If `req_i` is high and `addr_i[1:0] == 0`: latch `addr_i` into `addr_q`, load `cnt = WAIT_ST`, clear `kill`. Go to WAIT if `WAIT_ST > 0`, otherwise go to READ.
  - If `req_i` is high and `addr_i[1:0] != 0`: no memory access. Next cycle, `misalign_o` is 1, `instr_o` is `NOP`, `pc_o` is `addr_i`, and `instr_vld_o` is 0. Stay in IDLE.
- **WAIT:**
  - Decrement `cnt` each cycle; go to READ when `cnt == 1`.
  - If `flush_i` is high, go to IDLE next cycle with no read issued.
- **READ:**
  - `mem_rd` = 1 and `mem_addr` = `addr_q[ADDR_W+1:2]`, both combinational from state.
  - Go to RESP.
  - If `flush_i` is high, set `kill`; the read still completes.
- **RESP:**
  - Register `instr_o <= mem_rdata`, `pc_o <= addr_q`, and `instr_vld_o <= ~(kill | flush_i)`.
  - If the transaction was killed, `instr_o <= NOP`.
  - Go to IDLE.
- `stall_o = (state != IDLE)`, combinational.
- `instr_vld_o` and `misalign_o` are high for exactly one cycle per completed request. When not pulsing they are 0.
- `instr_o` and `pc_o` hold their last value between strobes.
- Address arithmetic:
  - Only `addr_i[ADDR_W+1:2]` reaches memory. Upper bits are ignored, so the address wraps modulo 2^ADDR_W words.
  - `pc_o` reports the full 32-bit latched address.
- `flush_i` in IDLE has no effect; a same-cycle `req_i` is accepted normally.
- `flush_i` in the cycle `instr_vld_o` is high does not retract the strobe. Decode-side flushing handles that case.
- `req_i` is ignored in WAIT, READ and RESP. No queueing; one transaction outstanding.

## Timing
- Reset values: state IDLE, `cnt` 0, `kill` 0, `addr_q` 0, `instr_o` = `NOP`, `pc_o` 0, `instr_vld_o` 0, `misalign_o` 0, `stall_o` 0, `mem_rd` 0, `mem_addr` 0.
- Reset asserted mid-transaction returns to IDLE immediately, with no strobe and no `mem_rd`.
- Latency from the `req_i` sample edge to `instr_vld_o` high is `3 + WAIT_ST` cycles:
  - Cycle 0: `req_i` sampled.
  - Cycles 1..WAIT_ST: WAIT.
  - Cycle WAIT_ST+1: READ.
  - Cycle WAIT_ST+2: RESP.
  - Cycle WAIT_ST+3: strobe, with the FSM already in IDLE.
- `stall_o` is high from cycle 1 through cycle WAIT_ST+2 and low in the strobe cycle. A new request can therefore be accepted in the strobe cycle.
- Back-to-back throughput is one instruction per `3 + WAIT_ST` cycles.
- Misaligned request: `misalign_o` is high in cycle 1; `stall_o` never rises.

## Test plan
- Reset, then `WAIT_ST=0`, `req_i=1`, `addr_i=0x0000_0010`, memory word 4 = 0x0040_0093 -> `mem_rd`=1 with `mem_addr`=4 in cycle 1; `instr_vld_o`=1, `instr_o`=0x0040_0093, `pc_o`=0x10 in cycle 3; `stall_o` high in cycles 1–2.
- `WAIT_ST=3`, `addr_i=0x8` -> `mem_rd` in cycle 4, strobe in cycle 6, `stall_o` high in cycles 1–5.
- `WAIT_ST=3`, `flush_i` pulsed in cycle 2 -> no `mem_rd`, no strobe, `stall_o` low from cycle 3.
- `WAIT_ST=0`, `flush_i` pulsed in the READ cycle -> `mem_rd` still pulses; in the next-cycle-but-one, `instr_vld_o`=0 and `instr_o`=0x0000_0013.
- `addr_i=0x0000_0006` -> `misalign_o`=1 and `pc_o`=0x6 in cycle 1; no `mem_rd`; `stall_o` stays 0.
- `ADDR_W=10`, `addr_i=0x0000_1004` -> `mem_addr`=1 (wrap), `pc_o`=0x1004.
- `resetn` dropped during WAIT -> all outputs take reset values asynchronously; no strobe after release.
